// File: rtl/p405s_timer_status_unit_if.sv
// p405s_timer_status_unit_if: SPR write bus into the timer status register unit.
interface p405s_timer_status_unit_if #(parameter int TSR_W = 6);
  logic PCL_mtSPR;
  logic PCL_sprHold;
  logic timerSetStatDcd;
  logic timerRstStatDcd;
  logic [0:TSR_W-1] EXE_sprDataBus;
  modport master(output PCL_mtSPR, PCL_sprHold, timerSetStatDcd, timerRstStatDcd, EXE_sprDataBus);
  modport slave(input PCL_mtSPR, PCL_sprHold, timerSetStatDcd, timerRstStatDcd, EXE_sprDataBus);
endinterface

// File: rtl/p405s_timer_status_unit.sv
// p405s_timer_status_unit: TSR with W1S/W1C access, watchdog state machine and interrupt/reset requests.
module p405s_timer_status_unit #(
  parameter int NUM_CH = 2,
  parameter logic [1:0] WRS_RST = 2'b00,
  parameter int TSR_W = 4 + NUM_CH
) (
  input  logic                  CB,
  input  logic                  resetCore,
  p405s_timer_status_unit_if.slave spr,
  input  logic                  wdPulse,
  input  logic                  wdIntEn,
  input  logic [0:1]            wdRstCtl,
  input  logic [0:NUM_CH-1]     chSetPulse,
  input  logic [0:NUM_CH-1]     chIntEn,
  output logic [0:TSR_W-1]      tsrL2,
  output logic                  wdIntReq,
  output logic [0:NUM_CH-1]     chIntReq,
  output logic                  wdRstReq,
  output logic [0:1]            wdRstType
);
  typedef enum logic [1:0] {WD_IDLE = 2'b00, WD_WIS = 2'b01, WD_ENW = 2'b10, WD_EXP = 2'b11} wd_state_t;
  wd_state_t wd_state;
  logic sw_wr, rst_fired, fire;
  logic [0:1] wd_set;
  logic [0:TSR_W-1] sw_val, tsr_nxt;
  // Watchdog state lives in the ENW/WIS bits themselves, taken before this cycle's write.
  assign wd_state = wd_state_t'({tsrL2[0], tsrL2[1]});
  assign sw_wr = spr.PCL_mtSPR & ~spr.PCL_sprHold & (spr.timerSetStatDcd | spr.timerRstStatDcd);
  assign sw_val = !sw_wr ? tsrL2 :
                  spr.timerRstStatDcd ? tsrL2 & ~spr.EXE_sprDataBus : tsrL2 | spr.EXE_sprDataBus;
  always_comb begin
    wd_set = 2'b00;
    fire = 1'b0;
    if (wdPulse) begin
      wd_set = (wd_state == WD_IDLE || wd_state == WD_WIS) ? 2'b10 : wd_state == WD_ENW ? 2'b01 : 2'b00;
      fire = wd_state == WD_EXP && wdRstCtl != 2'b00 && !rst_fired;
    end
    tsr_nxt = sw_val;
    tsr_nxt[0:1] = tsr_nxt[0:1] | wd_set;
    tsr_nxt[4:TSR_W-1] = tsr_nxt[4:TSR_W-1] | chSetPulse;
    if (fire) tsr_nxt[2:3] = wdRstCtl;
  end
  always_ff @(posedge CB) begin
    if (resetCore) begin
      tsrL2 <= {2'b00, WRS_RST, {NUM_CH{1'b0}}};
      wdRstReq <= 1'b0;
      wdRstType <= 2'b00;
      rst_fired <= 1'b0;
    end else begin
      tsrL2 <= tsr_nxt;
      wdRstReq <= fire;
      if (fire) wdRstType <= wdRstCtl;
      rst_fired <= rst_fired | fire;
    end
  end
  assign wdIntReq = tsrL2[1] & wdIntEn;
  assign chIntReq = tsrL2[4:TSR_W-1] & chIntEn;
endmodule
